// File: rtl/lru_pkg.sv
// Shared types and helpers for the 4-way LRU victim selector.
// Ages: 3 = most recently used, 0 = least recently used.
package lru_pkg;

  localparam int WAYS  = 4;
  localparam int AGE_W = 2;

  localparam logic [AGE_W-1:0] AGE_MRU = 2'd3;
  localparam logic [AGE_W-1:0] AGE_LRU = 2'd0;

  typedef logic [WAYS-1:0][AGE_W-1:0] age_vec_t;

  // way n starts at age n
  localparam age_vec_t AGE_RESET = {2'd3, 2'd2, 2'd1, 2'd0};

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    RESP
  } state_t;

  // Lowest invalid way wins; with all ways valid the age-0 way is taken.
  function automatic logic [1:0] pick_victim(
    input logic [WAYS-1:0] vmask,
    input age_vec_t        ages
  );
    logic [1:0] v;
    v = 2'd0;
    for (int i = WAYS-1; i >= 0; i--) begin
      if (ages[i] == AGE_LRU) v = 2'(i);
    end
    for (int i = WAYS-1; i >= 0; i--) begin
      if (!vmask[i]) v = 2'(i);
    end
    return v;
  endfunction

endpackage

// File: rtl/lru_age_promote.sv
// Combinational promotion of one way to MRU within a set's age vector.
// Ways younger than the promoted way age by one; older ways are untouched.
module lru_age_promote
  import lru_pkg::*;
(
  input  age_vec_t   i_ages,
  input  logic [1:0] i_way,
  output age_vec_t   o_ages
);

  logic [AGE_W-1:0] w_ref;

  assign w_ref = i_ages[i_way];

  always_comb begin
    o_ages = i_ages;
    for (int w = 0; w < WAYS; w++) begin
      if (2'(w) == i_way) begin
        o_ages[w] = AGE_MRU;
      end else if (i_ages[w] > w_ref) begin
        o_ages[w] = i_ages[w] - 2'd1;
      end
    end
  end

endmodule

// File: rtl/lru_victim_select.sv
// Per-set LRU age store with miss-side victim selection and hit touches.
// One shared promote unit: the commit slot blocks touches for that cycle.
module lru_victim_select
  import lru_pkg::*;
#(
  parameter int SETS  = 64,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [IDX_W-1:0] req_set,
  input  logic [3:0]       req_vmask,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [1:0]       rsp_way,
  output logic [IDX_W-1:0] rsp_set,
  input  logic             touch_valid,
  output logic             touch_ready,
  input  logic [IDX_W-1:0] touch_set,
  input  logic [1:0]       touch_way
);

  age_vec_t         r_ages [SETS];
  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_set;
  logic [3:0]       r_vmask;
  logic [1:0]       r_rsp_way;
  logic [IDX_W-1:0] r_rsp_set;

  logic             w_req_hs;
  logic             w_commit;
  logic             w_touch;
  logic             w_upd_en;
  logic [IDX_W-1:0] w_upd_set;
  logic [1:0]       w_upd_way;
  age_vec_t         w_upd_old;
  age_vec_t         w_upd_new;
  logic [1:0]       w_victim;

  assign req_ready   = rst_n && (r_state == IDLE);
  assign rsp_valid   = (r_state == RESP);
  assign touch_ready = rst_n && !(rsp_valid && rsp_ready);
  assign rsp_way     = r_rsp_way;
  assign rsp_set     = r_rsp_set;

  assign w_req_hs = req_valid && req_ready;
  assign w_commit = rsp_valid && rsp_ready;
  assign w_touch  = touch_valid && touch_ready;
  assign w_upd_en = w_commit || w_touch;

  assign w_upd_set = w_commit ? r_rsp_set : touch_set;
  assign w_upd_way = w_commit ? r_rsp_way : touch_way;
  assign w_upd_old = r_ages[w_upd_set];

  lru_age_promote u_promote (
    .i_ages (w_upd_old),
    .i_way  (w_upd_way),
    .o_ages (w_upd_new)
  );

  assign w_victim = pick_victim(r_vmask, r_ages[r_set]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_req_hs) w_state_nxt = LOOKUP;
      LOOKUP:  w_state_nxt = RESP;
      RESP:    if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_set     <= '0;
      r_vmask   <= '0;
      r_rsp_way <= '0;
      r_rsp_set <= '0;
    end else begin
      if (w_req_hs) begin
        r_set   <= req_set;
        r_vmask <= req_vmask;
      end
      if (r_state == LOOKUP) begin
        r_rsp_way <= w_victim;
        r_rsp_set <= r_set;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        r_ages[s] <= AGE_RESET;
      end
    end else if (w_upd_en) begin
      r_ages[w_upd_set] <= w_upd_new;
    end
  end

endmodule

// File: tb/tb_lru_victim_select.sv
// Directed and randomized checks for lru_victim_select.
// Ages are read hierarchically and compared with hand-derived values.
module tb_lru_victim_select;
  import lru_pkg::*;

  localparam int SETS  = 64;
  localparam int IDX_W = 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [IDX_W-1:0] req_set = '0;
  logic [3:0]       req_vmask = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [1:0]       rsp_way;
  logic [IDX_W-1:0] rsp_set;
  logic             touch_valid = 1'b0;
  logic             touch_ready;
  logic [IDX_W-1:0] touch_set = '0;
  logic [1:0]       touch_way = '0;

  always #5 clk = ~clk;

  lru_victim_select #(.SETS(SETS), .IDX_W(IDX_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_set     (req_set),
    .req_vmask   (req_vmask),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_way     (rsp_way),
    .rsp_set     (rsp_set),
    .touch_valid (touch_valid),
    .touch_ready (touch_ready),
    .touch_set   (touch_set),
    .touch_way   (touch_way)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [IDX_W-1:0] set;
    logic [3:0]       vmask;
    logic [1:0]       way;
    logic [7:0]       ages;
  } vec_t;

  vec_t vecs [10];

  // ages listed as way0, way1, way2, way3
  function automatic logic [7:0] a4(int a0, int a1, int a2, int a3);
    return {2'(a3), 2'(a2), 2'(a1), 2'(a0)};
  endfunction

  function automatic logic is_perm(logic [7:0] v);
    logic [3:0] seen;
    logic [1:0] a;
    seen = '0;
    for (int i = 0; i < 4; i++) begin
      a = v[2*i +: 2];
      seen[a] = 1'b1;
    end
    return seen == 4'hF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_miss(input logic [IDX_W-1:0] s, input logic [3:0] vm);
    int lat;
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 1);
    req_valid = 1'b1;
    req_set   = s;
    req_vmask = vm;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 6) begin
      @(negedge clk);
      lat++;
    end
    chk("rsp_latency", 32'(lat), 2);
  endtask

  task automatic commit();
    rsp_ready = 1'b1;
    #1;
    chk("touch_ready_commit", 32'(touch_ready), 0);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_after", 32'(rsp_valid), 0);
  endtask

  task automatic touch1(input logic [IDX_W-1:0] s, input logic [1:0] w);
    touch_valid = 1'b1;
    touch_set   = s;
    touch_way   = w;
    @(negedge clk);
    touch_valid = 1'b0;
  endtask

  initial begin
    int bad;

    vecs[0] = '{6'd5,  4'b1111, 2'd0, a4(3, 0, 1, 2)};
    vecs[1] = '{6'd9,  4'b1011, 2'd2, a4(0, 1, 3, 2)};
    vecs[2] = '{6'd5,  4'b1111, 2'd1, a4(2, 3, 0, 1)};
    vecs[3] = '{6'd5,  4'b0110, 2'd0, a4(3, 2, 0, 1)};
    vecs[4] = '{6'd9,  4'b1111, 2'd0, a4(3, 0, 2, 1)};
    vecs[5] = '{6'd63, 4'b0000, 2'd0, a4(3, 0, 1, 2)};
    vecs[6] = '{6'd0,  4'b1110, 2'd0, a4(3, 0, 1, 2)};
    vecs[7] = '{6'd0,  4'b1111, 2'd1, a4(2, 3, 0, 1)};
    vecs[8] = '{6'd0,  4'b1111, 2'd2, a4(1, 2, 3, 0)};
    vecs[9] = '{6'd0,  4'b0111, 2'd3, a4(0, 1, 2, 3)};

    #2;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_touch_ready", 32'(touch_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_rsp_way", 32'(rsp_way), 0);
    chk("rst_rsp_set", 32'(rsp_set), 0);
    chk("rst_ages_set5", 32'(dut.r_ages[5]), 32'(a4(0, 1, 2, 3)));

    for (int i = 0; i < 10; i++) begin
      start_miss(vecs[i].set, vecs[i].vmask);
      chk($sformatf("vec%0d_way", i), 32'(rsp_way), 32'(vecs[i].way));
      chk($sformatf("vec%0d_set", i), 32'(rsp_set), 32'(vecs[i].set));
      commit();
      chk($sformatf("vec%0d_ages", i), 32'(dut.r_ages[vecs[i].set]),
          32'(vecs[i].ages));
    end

    // back-to-back touches, then a miss on the same set
    @(negedge clk);
    touch_valid = 1'b1;
    touch_set   = 6'd3;
    touch_way   = 2'd0;
    @(negedge clk);
    touch_way = 2'd1;
    @(negedge clk);
    touch_way = 2'd2;
    @(negedge clk);
    touch_valid = 1'b0;
    chk("touch_seq_ages", 32'(dut.r_ages[3]), 32'(a4(1, 2, 3, 0)));
    start_miss(6'd3, 4'b1111);
    chk("touch_seq_way", 32'(rsp_way), 3);
    commit();
    chk("touch_seq_commit", 32'(dut.r_ages[3]), 32'(a4(0, 1, 2, 3)));

    // response held off for five cycles
    start_miss(6'd7, 4'b1111);
    for (int c = 0; c < 5; c++) begin
      chk("hold_rsp_valid", 32'(rsp_valid), 1);
      chk("hold_rsp_way", 32'(rsp_way), 0);
      chk("hold_rsp_set", 32'(rsp_set), 7);
      chk("hold_req_ready", 32'(req_ready), 0);
      chk("hold_touch_ready", 32'(touch_ready), 1);
      @(negedge clk);
    end
    commit();
    chk("hold_ages", 32'(dut.r_ages[7]), 32'(a4(3, 0, 1, 2)));

    // touch on the victim way while waiting in RESP
    start_miss(6'd12, 4'b1111);
    touch1(6'd12, 2'd0);
    chk("resp_touch_mid", 32'(dut.r_ages[12]), 32'(a4(3, 0, 1, 2)));
    commit();
    chk("resp_touch_victim", 32'(dut.r_ages[12]), 32'(a4(3, 0, 1, 2)));
    chk("resp_touch_perm", 32'(is_perm(dut.r_ages[12])), 1);

    // touch on another way in RESP: commit sees post-touch ages
    start_miss(6'd14, 4'b1111);
    touch1(6'd14, 2'd2);
    chk("resp_touch2_way", 32'(rsp_way), 0);
    commit();
    chk("resp_touch2_ages", 32'(dut.r_ages[14]), 32'(a4(3, 0, 2, 1)));

    // touch during LOOKUP does not re-select the victim
    @(negedge clk);
    req_valid = 1'b1;
    req_set   = 6'd13;
    req_vmask = 4'b1111;
    @(negedge clk);
    req_valid = 1'b0;
    touch1(6'd13, 2'd0);
    chk("lookup_touch_valid", 32'(rsp_valid), 1);
    chk("lookup_touch_way", 32'(rsp_way), 0);
    commit();
    chk("lookup_touch_ages", 32'(dut.r_ages[13]), 32'(a4(3, 0, 1, 2)));

    // asynchronous reset while a response is pending
    start_miss(6'd20, 4'b1111);
    chk("pre_rst_set", 32'(rsp_set), 20);
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 0);
    chk("midrst_req_ready", 32'(req_ready), 0);
    chk("midrst_touch_ready", 32'(touch_ready), 0);
    bad = 0;
    for (int s = 0; s < SETS; s++) begin
      if (dut.r_ages[s] !== a4(0, 1, 2, 3)) bad++;
    end
    chk("midrst_all_ages", 32'(bad), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_rsp_way", 32'(rsp_way), 0);
    chk("midrst_rsp_set", 32'(rsp_set), 0);
    chk("midrst_rsp_valid2", 32'(rsp_valid), 0);

    // random contention on a few sets
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      touch_valid = 1'($urandom_range(0, 1));
      touch_set   = 6'($urandom_range(0, 7));
      touch_way   = 2'($urandom_range(0, 3));
      req_valid   = 1'($urandom_range(0, 1));
      req_set     = 6'($urandom_range(0, 7));
      req_vmask   = 4'($urandom_range(0, 15));
      rsp_ready   = 1'($urandom_range(0, 1));
      chk("rand_perm", 32'(is_perm(dut.r_ages[c % 8])), 1);
    end
    @(negedge clk);
    touch_valid = 1'b0;
    req_valid   = 1'b0;
    rsp_ready   = 1'b0;
    bad = 0;
    for (int s = 0; s < SETS; s++) begin
      if (!is_perm(dut.r_ages[s])) bad++;
    end
    chk("rand_all_perm", 32'(bad), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
